// File: rtl/motion_nios_debug_ocimem_arbiter.sv
// rtl/motion_nios_debug_ocimem_arbiter.sv - round-robin OCI RAM arbiter between the JTAG debug path and the Avalon debug slave
module motion_nios_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_err,
  output logic              jtag_ovf,
  input  logic              debugack,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_J = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                j_pend_q, j_pend_d;
  logic                j_wr_q;
  logic [ADDR_W-1:0]   j_addr_q;
  logic [DATA_W-1:0]   j_wdata_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   j_hold_q, a_hold_q;

  logic                a_pend, ack_j, ack_a, in_issue;
  logic                j_accept, j_want, a_want, j_blocked;
  logic                wr_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;

  // Request qualification: a J pulse landing in J's own ACK cycle is taken, and the
  // requester being acknowledged this cycle does not count as still pending.
  always_comb begin
    a_pend    = av_read | av_write;
    ack_j     = (state_q == ACK) & (owner_q == OWN_J);
    ack_a     = (state_q == ACK) & (owner_q == OWN_A);
    in_issue  = (state_q == ISSUE);
    j_accept  = jtag_req & (~j_pend_q | ack_j);
    j_pend_d  = (j_pend_q & ~ack_j) | j_accept;
    j_want    = (j_pend_q & ~ack_j) | j_accept;
    a_want    = a_pend & ~ack_a;
    wr_sel    = (owner_q == OWN_J) ? j_wr_q    : av_write;
    addr_sel  = (owner_q == OWN_J) ? j_addr_q  : av_address;
    wdata_sel = (owner_q == OWN_J) ? j_wdata_q : av_writedata;
    j_blocked = in_issue & (owner_q == OWN_J) & j_wr_q & ~debugack;
  end

  // Access sequencing and round-robin grant; IDLE and ACK share the arbitration step.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, ACK: begin
        state_d = IDLE;
        if (j_want | a_want) begin
          state_d = ISSUE;
          owner_d = (j_want & a_want) ? ~last_q : (j_want ? OWN_J : OWN_A);
          last_d  = owner_d;
        end
      end
      ISSUE: begin
        state_d = CAPT;
        err_d   = j_blocked;
        rd_d    = ~wr_sel;
      end
      CAPT: begin
        state_d = ACK;
        if (rd_q) rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state; RAM strobes only appear in ISSUE.
  always_comb begin
    mem_en         = in_issue & ~j_blocked;
    mem_wr         = mem_en & wr_sel;
    mem_addr       = in_issue ? addr_sel  : '0;
    mem_wdata      = in_issue ? wdata_sel : '0;
    jtag_done      = ack_j;
    jtag_err       = ack_j & err_q;
    jtag_rdata     = ack_j ? rdata_q : j_hold_q;
    jtag_ovf       = ovf_q;
    av_waitrequest = a_pend & ~ack_a;
    av_readdata    = ack_a ? rdata_q : a_hold_q;
  end

  // FSM, grant history and read-data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      last_q  <= OWN_A;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  // JTAG command capture and sticky overflow on pulses dropped while one is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j_pend_q  <= 1'b0;
      j_wr_q    <= 1'b0;
      j_addr_q  <= '0;
      j_wdata_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      j_pend_q <= j_pend_d;
      if (j_accept) begin
        j_wr_q    <= jtag_wr;
        j_addr_q  <= jtag_addr;
        j_wdata_q <= jtag_wdata;
      end
      if (jtag_req & ~j_accept) ovf_q <= 1'b1;
    end
  end

  // Per-requester copies so each read-data output holds its value outside ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j_hold_q <= '0;
      a_hold_q <= '0;
    end else begin
      if (ack_j) j_hold_q <= rdata_q;
      if (ack_a) a_hold_q <= rdata_q;
    end
  end

endmodule

// File: tb/tb_motion_nios_debug_ocimem_arbiter.sv
// tb/tb_motion_nios_debug_ocimem_arbiter.sv - directed and randomized checks of the OCI RAM arbiter against a reference model
module tb_motion_nios_debug_ocimem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          jtag_req, jtag_wr;
  logic [AW-1:0] jtag_addr;
  logic [DW-1:0] jtag_wdata, jtag_rdata;
  logic          jtag_done, jtag_err, jtag_ovf;
  logic          debugack;
  logic          av_read, av_write, av_waitrequest;
  logic [AW-1:0] av_address;
  logic [DW-1:0] av_writedata, av_readdata;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  motion_nios_debug_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_err(jtag_err), .jtag_ovf(jtag_ovf),
    .debugack(debugack),
    .av_read(av_read), .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    return (32'(a) * 32'h01000193) ^ 32'h13572468;
  endfunction

  // OCI RAM: single port, read data one cycle after mem_en
  logic [DW-1:0] ram [0:255];
  logic          ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: an access granted at cycle g touches RAM at g+1 and completes at g+3
  logic [DW-1:0] exp_mem [0:255];
  logic          m_busy, m_owner, m_last, m_jpend, m_jwr, m_ovf, m_err, m_isread;
  logic [AW-1:0] m_jaddr;
  logic [DW-1:0] m_jwdata, m_rdata, m_rnext, m_jhold, m_avhold;
  int            m_gcyc;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 0; m_jpend = 0; m_jwr = 0; m_ovf = 0;
    m_err = 0; m_isread = 0; m_jaddr = '0; m_jwdata = '0; m_rdata = '0;
    m_rnext = '0; m_jhold = '0; m_avhold = '0; m_gcyc = 0;
  endtask

  task automatic model_cycle(input logic rst);
    int            phase;
    logic          issue, capt, ack, apend, blocked, e_en, e_wr, e_done, ack_a;
    logic          jclr, jp_old, jacc, javail, aavail;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (rst) model_reset();
    phase   = m_busy ? (cyc - m_gcyc) : 0;
    issue   = m_busy && (phase == 1);
    capt    = m_busy && (phase == 2);
    ack     = m_busy && (phase == 3);
    apend   = av_read || av_write;
    ack_a   = ack && !m_owner;
    e_wr    = m_owner ? m_jwr : av_write;
    e_addr  = m_owner ? m_jaddr : av_address;
    e_wd    = m_owner ? m_jwdata : av_writedata;
    blocked = issue && m_owner && m_jwr && !debugack;
    e_en    = issue && !blocked;
    e_done  = ack && m_owner;

    check("mem_en", mem_en, e_en);
    if (e_en) begin
      check("mem_wr", mem_wr, e_wr);
      check("mem_addr", mem_addr, e_addr);
      if (e_wr) check("mem_wdata", mem_wdata, e_wd);
    end
    check("jtag_done", jtag_done, e_done);
    check("jtag_err", jtag_err, e_done && m_err);
    check("jtag_rdata", jtag_rdata, e_done ? m_rdata : m_jhold);
    check("av_waitrequest", av_waitrequest, apend && !ack_a);
    check("av_readdata", av_readdata, ack_a ? m_rdata : m_avhold);
    check("jtag_ovf", jtag_ovf, m_ovf);

    if (!rst) begin
      jclr   = ack && m_owner;
      jp_old = m_jpend;
      jacc   = jtag_req && (!jp_old || jclr);
      javail = (jp_old && !jclr) || jacc;
      aavail = apend && !ack_a;
      if (issue) begin
        m_err    = blocked;
        m_isread = !e_wr;
        m_rnext  = exp_mem[e_addr];
        if (e_en && e_wr) exp_mem[e_addr] = e_wd;
      end
      if (capt && m_isread) m_rdata = m_rnext;
      if (ack) begin
        if (m_owner) m_jhold = m_rdata;
        else         m_avhold = m_rdata;
      end
      if (!m_busy || ack) begin
        m_busy = javail || aavail;
        if (m_busy) begin
          m_owner = (javail && aavail) ? !m_last : javail;
          m_last  = m_owner;
          m_gcyc  = cyc;
        end
      end
      if (jclr) m_jpend = 0;
      if (jtag_req) begin
        if (jacc) begin
          m_jpend = 1; m_jwr = jtag_wr; m_jaddr = jtag_addr; m_jwdata = jtag_wdata;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  // Avalon master: holds its request until it sees waitrequest low
  logic          a_active = 0, a_acked = 0;
  logic          a_q_valid = 0, a_q_wr = 0;
  logic [AW-1:0] a_q_addr = '0;
  logic [DW-1:0] a_q_data = '0;
  logic          dack_next = 1;

  int            ev_jdone[$];
  int            ev_aack[$];
  int            ev_men[$];
  logic [DW-1:0] ev_jrd[$];
  logic          ev_jerr[$];
  logic [DW-1:0] ev_ard[$];

  task automatic clear_logs();
    ev_jdone.delete(); ev_aack.delete(); ev_men.delete();
    ev_jrd.delete(); ev_jerr.delete(); ev_ard.delete();
  endtask

  task automatic a_post(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    a_q_valid = 1; a_q_wr = wr; a_q_addr = a; a_q_data = d;
  endtask

  task automatic step(input logic rst, input logic jreq, input logic jwr,
                      input logic [AW-1:0] ja, input logic [DW-1:0] jd);
    @(posedge clk);
    #1;
    cyc++;
    reset_n    = ~rst;
    jtag_req   = jreq;
    jtag_wr    = jwr;
    jtag_addr  = ja;
    jtag_wdata = jd;
    debugack   = dack_next;
    if (a_active && a_acked) begin
      a_active = 0; av_read = 0; av_write = 0;
    end
    a_acked = 0;
    if (!a_active && a_q_valid) begin
      a_active = 1; a_q_valid = 0;
      av_read = ~a_q_wr; av_write = a_q_wr; av_address = a_q_addr; av_writedata = a_q_data;
    end
    @(negedge clk);
    model_cycle(rst);
    if (jtag_done) begin
      ev_jdone.push_back(cyc); ev_jrd.push_back(jtag_rdata); ev_jerr.push_back(jtag_err);
    end
    if (mem_en) ev_men.push_back(cyc);
    if (a_active && !av_waitrequest && !rst) begin
      a_acked = 1; ev_aack.push_back(cyc); ev_ard.push_back(av_readdata);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  int c0;

  initial begin
    reset_n = 0; ram_init = 1;
    jtag_req = 0; jtag_wr = 0; jtag_addr = '0; jtag_wdata = '0; debugack = 1;
    av_read = 0; av_write = 0; av_address = '0; av_writedata = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    model_reset();
    @(posedge clk);
    #1 ram_init = 0;
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    check("reset_waitreq", av_waitrequest, 0);
    check("reset_mem_en", mem_en, 0);

    // J read of preloaded word
    clear_logs(); c0 = cyc + 1;
    step(0, 1, 0, 8'h10, '0);
    idle(5);
    check("jrd_mem_en_cycle", (ev_men.size() > 0) ? ev_men[0] - c0 : -1, 1);
    check("jrd_done_count", ev_jdone.size(), 1);
    check("jrd_done_cycle", (ev_jdone.size() > 0) ? ev_jdone[0] - c0 : -1, 3);
    check("jrd_data", (ev_jrd.size() > 0) ? ev_jrd[0] : '0, 32'hDEADBEEF);
    check("jrd_err", (ev_jerr.size() > 0) ? ev_jerr[0] : 1'b1, 0);

    // J write refused while the CPU is not in debug mode
    clear_logs(); dack_next = 0;
    step(0, 1, 1, 8'h20, 32'h1234);
    idle(5);
    check("jwr_blk_mem_en_count", ev_men.size(), 0);
    check("jwr_blk_done_count", ev_jdone.size(), 1);
    check("jwr_blk_err", (ev_jerr.size() > 0) ? ev_jerr[0] : 1'b0, 1);
    check("jwr_blk_ram", ram[8'h20], init_val('h20));

    // Same write accepted in debug mode
    clear_logs(); dack_next = 1;
    step(0, 1, 1, 8'h20, 32'h1234);
    idle(5);
    check("jwr_ok_mem_en_count", ev_men.size(), 1);
    check("jwr_ok_err", (ev_jerr.size() > 0) ? ev_jerr[0] : 1'b1, 0);
    check("jwr_ok_ram", ram[8'h20], 32'h1234);

    // Contention out of reset: J first, then strict alternation every 3 cycles
    step(1, 0, 0, '0, '0);
    clear_logs(); c0 = cyc + 1;
    for (int k = 0; k < 20; k++) begin
      a_post(0, 8'h10, '0);
      step(0, (k == 0) || (k % 6 == 3 && k < 18), 0, 8'h20, '0);
    end
    a_q_valid = 0;
    idle(12);
    for (int i = 0; i < 3; i++) begin
      check("cont_jdone_cycle", (ev_jdone.size() > i) ? ev_jdone[i] - c0 : -1, 3 + 6 * i);
      check("cont_aack_cycle", (ev_aack.size() > i) ? ev_aack[i] - c0 : -1, 6 + 6 * i);
    end
    check("cont_jdata", (ev_jrd.size() > 0) ? ev_jrd[0] : '0, 32'h1234);
    check("cont_adata", (ev_ard.size() > 0) ? ev_ard[0] : '0, 32'hDEADBEEF);
    check("cont_no_ovf", jtag_ovf, 0);

    // Avalon write then read back
    clear_logs(); c0 = cyc + 1;
    a_post(1, 8'h05, 32'hA5A5A5A5);
    idle(6);
    check("av_wr_ack_cycle", (ev_aack.size() > 0) ? ev_aack[0] - c0 : -1, 3);
    clear_logs();
    a_post(0, 8'h05, '0);
    idle(6);
    check("av_rd_data", (ev_ard.size() > 0) ? ev_ard[0] : '0, 32'hA5A5A5A5);

    // Overflow: second pulse while pending is dropped, flag is sticky
    clear_logs();
    step(0, 1, 0, 8'h10, '0);
    step(0, 1, 0, 8'h11, '0);
    idle(8);
    check("ovf_set", jtag_ovf, 1);
    check("ovf_done_count", ev_jdone.size(), 1);
    check("ovf_first_kept", (ev_jrd.size() > 0) ? ev_jrd[0] : '0, 32'hDEADBEEF);

    // Reset during CAPT of a J read
    clear_logs();
    step(0, 1, 0, 8'h10, '0);
    idle(1);
    step(1, 0, 0, '0, '0);
    check("rst_mid_ovf", jtag_ovf, 0);
    check("rst_mid_done", jtag_done, 0);
    clear_logs(); c0 = cyc + 1;
    a_post(0, 8'h05, '0);
    idle(8);
    check("rst_mid_no_jdone", ev_jdone.size(), 0);
    check("rst_mid_idle_latency", (ev_aack.size() > 0) ? ev_aack[0] - c0 : -1, 3);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic r, jq;
      r  = ($urandom_range(199) == 0);
      jq = !r && ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) dack_next = ~dack_next;
      if (!a_q_valid && !a_active && $urandom_range(2) == 0)
        a_post($urandom_range(1), AW'($urandom_range(15)), $urandom);
      step(r, jq, $urandom_range(1), AW'($urandom_range(15)), $urandom);
    end
    a_q_valid = 0;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
